nios2_ocimem_monitor: RTL and testbench

//  System-clock consumer of the JTAG debug module's decoded commands (jdo + take_action_ocimem_*).

---
 rtl/nios2_ocimem_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_nios2_ocimem_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ocimem_monitor.sv
// Purpose: system-clock side of the on-chip debug monitor. Executes JTAG
// debug-module commands (load address, read-next, write) against the monitor
// RAM through MonAReg/MonDReg, and shares that RAM with a CPU-side Avalon-MM
// slave. JTAG has priority over Avalon.
// Ports:
//   clk, reset_n             system clock, async active-low reset
//   jdo, take_*_ocimem_*     decoded JTAG command pulses and their payload
//   av_*                     Avalon-MM slave (RAM page + status word at 0x100)
//   MonDReg                  last JTAG-read RAM word
//   monitor_ready/_error     sticky flags, set by CPU, cleared by JTAG
//   cmd_overrun              sticky, a JTAG command pulse was dropped
module nios2_ocimem_monitor #(
  parameter int unsigned RAM_AW   = 8,
  parameter string       RAM_INIT = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [8:0]  av_address,
  input  logic        av_chipselect,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  output logic        cmd_overrun
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;
  localparam int unsigned DW        = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_JRD, S_JRD_CAP, S_JWR, S_AV_RD, S_AV_RD_DATA, S_AV_WR
  } state_t;

  state_t              state_q;
  logic [RAM_AW-1:0]   mon_a_q;
  logic [DW-1:0]       mon_d_q;
  logic [DW-1:0]       av_rdata_q;
  logic                av_ack_q;
  logic                ready_q, error_q, overrun_q;
  // one-deep pending JTAG command slot
  logic                pend_vld_q, pend_wr_q, pend_inc_q;
  logic [DW-1:0]       pend_data_q;
  // command currently being executed
  logic                cur_inc_q;
  logic [DW-1:0]       cur_data_q;

  logic [DW-1:0]       mem [RAM_WORDS];
  logic [DW-1:0]       ram_q;

  // The RAM carries no reset; any RAM_INIT preload is applied to the memory
  // macro by the implementation flow, so the RTL only records the file name.
  if (RAM_INIT != "") begin : g_ram_preload
  end

  // Incoming JTAG command arbitration: write beats load-read beats read-next.
  logic              a_load, new_vld, new_wr, new_inc, multi_req;
  logic [DW-1:0]     new_data;
  logic              is_idle, dispatch_pend, dispatch_new, store_new, drop_new;
  logic              load_accept, overrun_set, av_req;
  logic [RAM_AW-1:0] av_word, load_addr;
  logic              status_word0;
  logic [DW-1:0]     status_rd;

  assign a_load    = take_action_ocimem_a & jdo[25];
  assign new_vld   = take_action_ocimem_b | a_load | take_no_action_ocimem_a;
  assign new_wr    = take_action_ocimem_b;
  assign new_inc   = ~take_action_ocimem_b & ~a_load;
  assign new_data  = jdo[34:3];
  assign multi_req = (2'(take_action_ocimem_b) + 2'(a_load) +
                      2'(take_no_action_ocimem_a)) > 2'd1;
  assign load_addr = jdo[25+RAM_AW:26];

  // IDLE consumes the slot (or the incoming pulse directly when the slot is
  // empty), so a pulse arriving in IDLE always finds room.
  assign is_idle       = (state_q == S_IDLE);
  assign dispatch_pend = is_idle & pend_vld_q;
  assign dispatch_new  = is_idle & ~pend_vld_q & new_vld;
  assign store_new     = new_vld & ~dispatch_new & (~pend_vld_q | is_idle);
  assign drop_new      = new_vld & pend_vld_q & ~is_idle;
  assign load_accept   = a_load & ~take_action_ocimem_b & (dispatch_new | store_new);
  assign overrun_set   = multi_req | drop_new;

  assign av_req         = av_chipselect & (av_read | av_write);
  assign av_waitrequest = av_req & ~av_ack_q;
  assign av_word        = av_address[RAM_AW-1:0];
  assign status_word0   = (av_address[7:0] == 8'd0);
  assign status_rd      = status_word0 ? {29'd0, overrun_q, error_q, ready_q} : '0;

  // RAM port control
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0]     ram_wdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = mon_a_q;
    ram_wdata = cur_data_q;
    ram_raddr = mon_a_q;
    if (state_q == S_JWR) begin
      ram_we = 1'b1;
    end else if (state_q == S_AV_WR && !av_address[8]) begin
      ram_we    = 1'b1;
      ram_waddr = av_word;
      ram_wdata = av_writedata;
    end
    if (state_q == S_AV_RD) ram_raddr = av_word;
  end

  // Monitor RAM, synchronous read, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  // Control FSM, command slot and monitor registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      av_rdata_q  <= '0;
      av_ack_q    <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      overrun_q   <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_inc_q  <= 1'b0;
      pend_data_q <= '0;
      cur_inc_q   <= 1'b0;
      cur_data_q  <= '0;
    end else begin
      av_ack_q <= 1'b0;

      if (store_new) begin
        pend_vld_q  <= 1'b1;
        pend_wr_q   <= new_wr;
        pend_inc_q  <= new_inc;
        pend_data_q <= new_data;
      end else if (dispatch_pend) begin
        pend_vld_q <= 1'b0;
      end

      // JTAG clears come first so a same-edge CPU set wins
      if (take_action_ocimem_a && jdo[35]) error_q <= 1'b0;
      if (take_action_ocimem_a && jdo[34]) ready_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (dispatch_pend) begin
            cur_inc_q  <= pend_inc_q;
            cur_data_q <= pend_data_q;
            state_q    <= pend_wr_q ? S_JWR : S_JRD;
          end else if (dispatch_new) begin
            cur_inc_q  <= new_inc;
            cur_data_q <= new_data;
            state_q    <= new_wr ? S_JWR : S_JRD;
          end else if (av_req && !av_ack_q) begin
            state_q <= av_write ? S_AV_WR : S_AV_RD;
          end
        end
        S_JRD:     state_q <= S_JRD_CAP;
        S_JRD_CAP: begin
          mon_d_q <= ram_q;
          if (cur_inc_q) mon_a_q <= mon_a_q + RAM_AW'(1);
          state_q <= S_IDLE;
        end
        S_JWR: begin
          mon_a_q <= mon_a_q + RAM_AW'(1);
          state_q <= S_IDLE;
        end
        S_AV_RD:   state_q <= S_AV_RD_DATA;
        S_AV_RD_DATA: begin
          av_rdata_q <= av_address[8] ? status_rd : ram_q;
          av_ack_q   <= 1'b1;
          state_q    <= S_IDLE;
        end
        S_AV_WR: begin
          if (av_address[8] && status_word0) begin
            if (av_writedata[0]) ready_q   <= 1'b1;
            if (av_writedata[1]) error_q   <= 1'b1;
            if (av_writedata[2]) overrun_q <= 1'b0;
          end
          av_ack_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (overrun_set) overrun_q <= 1'b1;
      // an accepted address load overrides any increment on the same edge
      if (load_accept) mon_a_q <= load_addr;
    end
  end

  logic unused_jdo_c;
  assign unused_jdo_c = ^{jdo[37:36], jdo[2:0]};

  assign av_readdata   = av_rdata_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign cmd_overrun   = overrun_q;

endmodule

// File: tb/tb_nios2_ocimem_monitor.sv
// Directed bench for nios2_ocimem_monitor: Avalon and JTAG traffic with
// scoreboard queues for Avalon read data and JTAG MonDReg captures.
module tb_nios2_ocimem_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [8:0]  av_address;
  logic        av_chipselect, av_read, av_write;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, cmd_overrun;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_av[$];
  logic [31:0] sb_jtag[$];
  logic [31:0] mon_exp = 32'd0;

  localparam int K_A = 0, K_NA = 1, K_B = 2, K_NONE = 3;

  nios2_ocimem_monitor dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .av_address(av_address), .av_chipselect(av_chipselect),
    .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error), .cmd_overrun(cmd_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jd_load(input logic [7:0] a);
    logic [37:0] j;
    j = '0; j[25] = 1'b1; j[33:26] = a;
    return j;
  endfunction

  function automatic logic [37:0] jd_wr(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  function automatic logic [37:0] jd_clr(input logic clr_err, input logic clr_rdy);
    logic [37:0] j;
    j = '0; j[35] = clr_err; j[34] = clr_rdy;
    return j;
  endfunction

  task automatic set_pulse(input int kind, input logic [37:0] j);
    take_action_ocimem_a    = (kind == K_A);
    take_no_action_ocimem_a = (kind == K_NA);
    take_action_ocimem_b    = (kind == K_B);
    jdo = j;
  endtask

  // one-cycle pulse; returns at the negedge after the pulse edge
  task automatic pulse(input int kind, input logic [37:0] j);
    @(negedge clk); set_pulse(kind, j);
    @(negedge clk); set_pulse(K_NONE, '0);
  endtask

  // JTAG read: MonDReg must still hold the old value one edge after the
  // pulse edge and the new one two edges after it
  task automatic jtag_read(input string tag, input int kind, input logic [37:0] j,
                           input logic [31:0] exp);
    sb_jtag.push_back(exp);
    pulse(kind, j);
    @(negedge clk);
    check({tag, "_early"}, MonDReg, mon_exp);
    @(negedge clk);
    mon_exp = sb_jtag.pop_front();
    check(tag, MonDReg, mon_exp);
  endtask

  // Avalon transfer, optionally with a JTAG pulse in cycle jt_at of the
  // request; hi counts cycles with waitrequest high
  task automatic av_xfer(input string tag, input bit wr, input logic [8:0] addr,
                         input logic [31:0] wd, input int jt_at, input int jt_kind,
                         input logic [37:0] jt_jdo, output int hi);
    int k;
    @(negedge clk);
    av_chipselect = 1'b1; av_read = !wr; av_write = wr;
    av_address = addr; av_writedata = wd;
    hi = 0; k = 0;
    while (k < 40) begin
      if (k == jt_at) set_pulse(jt_kind, jt_jdo);
      else set_pulse(K_NONE, '0);
      #1;
      if (!av_waitrequest) break;
      hi++;
      @(negedge clk);
      k++;
    end
    set_pulse(K_NONE, '0);
    if (av_waitrequest) begin
      check({tag, "_timeout"}, 32'(av_waitrequest), 32'd0);
    end else if (!wr) begin
      check(tag, av_readdata, sb_av.pop_front());
    end
    av_chipselect = 1'b0; av_read = 1'b0; av_write = 1'b0;
  endtask

  task automatic av_wr(input logic [8:0] addr, input logic [31:0] d);
    int hi;
    av_xfer("av_wr", 1'b1, addr, d, -1, K_NONE, '0, hi);
  endtask

  task automatic av_rd(input string tag, input logic [8:0] addr, input logic [31:0] exp);
    int hi;
    sb_av.push_back(exp);
    av_xfer(tag, 1'b0, addr, 32'd0, -1, K_NONE, '0, hi);
  endtask

  task automatic check_flags(input string tag, input logic r, input logic e, input logic o);
    check(tag, {29'd0, cmd_overrun, monitor_error, monitor_ready}, {29'd0, o, e, r});
  endtask

  initial begin
    int hi;
    reset_n = 1'b0;
    set_pulse(K_NONE, '0);
    av_address = '0; av_chipselect = 1'b0; av_read = 1'b0; av_write = 1'b0;
    av_writedata = '0;

    // reset state
    @(negedge clk);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_readdata", av_readdata, 32'd0);
    check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
    check("rst_waitreq", 32'(av_waitrequest), 32'd0);
    reset_n = 1'b1;

    // preload RAM; write = 1 wait state, read = 2 wait states
    av_xfer("wr_lat", 1'b1, 9'h010, 32'hCAFE0001, -1, K_NONE, '0, hi);
    check("wr_waitstates", 32'(hi - 1), 32'd1);
    sb_av.push_back(32'hCAFE0001);
    av_xfer("rd_0x10", 1'b0, 9'h010, 32'd0, -1, K_NONE, '0, hi);
    check("rd_waitstates", 32'(hi - 1), 32'd2);
    av_wr(9'h011, 32'hBEEF0011);
    av_wr(9'h0FF, 32'h0000_00FF);
    av_wr(9'h000, 32'hA5A50000);
    av_wr(9'h020, 32'h20202020);
    av_wr(9'h030, 32'h30303030);
    av_wr(9'h031, 32'h31313131);
    av_wr(9'h032, 32'h32323232);
    av_wr(9'h033, 32'h33333333);

    // load address 0x10: read without post-increment, then read-next twice
    jtag_read("jload_0x10", K_A, jd_load(8'h10), 32'hCAFE0001);
    jtag_read("jnext_0x10", K_NA, '0, 32'hCAFE0001);
    jtag_read("jnext_0x11", K_NA, '0, 32'hBEEF0011);

    // write at 0xFF wraps MonAReg to 0x00
    jtag_read("jload_0xff", K_A, jd_load(8'hFF), 32'h0000_00FF);
    pulse(K_B, jd_wr(32'h12345678));
    @(negedge clk);
    jtag_read("jnext_wrap", K_NA, '0, 32'hA5A50000);
    av_rd("rd_0xff", 9'h0FF, 32'h12345678);

    // contention: JTAG write to 0x20 and Avalon read of 0x20 on the same edge
    jtag_read("jload_0x20", K_A, jd_load(8'h20), 32'h20202020);
    sb_av.push_back(32'h77777777);
    av_xfer("contend_rd", 1'b0, 9'h020, 32'd0, 0, K_B, jd_wr(32'h77777777), hi);
    check("contend_waitstates", 32'(hi - 1), 32'd4);

    // status: CPU sets, JTAG clears, same-edge set beats clear
    av_wr(9'h100, 32'd3);
    check_flags("status_set", 1'b1, 1'b1, 1'b0);
    av_rd("status_rd3", 9'h100, 32'd3);
    pulse(K_A, jd_clr(1'b1, 1'b1));
    check_flags("status_jclr", 1'b0, 1'b0, 1'b0);
    av_xfer("status_setclr", 1'b1, 9'h100, 32'd3, 1, K_A, jd_clr(1'b1, 1'b1), hi);
    @(negedge clk);
    check_flags("setclr_set_wins", 1'b1, 1'b1, 1'b0);
    pulse(K_A, jd_clr(1'b1, 1'b1));

    // overrun: three consecutive read-next pulses from IDLE
    jtag_read("jload_0x30", K_A, jd_load(8'h30), 32'h30303030);
    @(negedge clk); set_pulse(K_NA, '0);
    @(negedge clk); set_pulse(K_NA, '0);
    @(negedge clk); set_pulse(K_NA, '0);
    @(negedge clk); set_pulse(K_NONE, '0);
    repeat (5) @(negedge clk);
    check_flags("overrun_flag", 1'b0, 1'b0, 1'b1);
    mon_exp = 32'h31313131;
    check("overrun_second", MonDReg, mon_exp);
    av_rd("status_rd4", 9'h100, 32'd4);
    jtag_read("overrun_third_dropped", K_NA, '0, 32'h32323232);
    av_wr(9'h100, 32'd4);
    av_rd("status_rd0", 9'h100, 32'd0);

    // reset in the middle of a JTAG read
    pulse(K_A, jd_load(8'h10));
    reset_n = 1'b0;
    #1;
    check("midrst_mondreg", MonDReg, 32'd0);
    check("midrst_readdata", av_readdata, 32'd0);
    check_flags("midrst_flags", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_exp = 32'd0;
    av_rd("midrst_ram_0x10", 9'h010, 32'hCAFE0001);
    jtag_read("midrst_next_0x00", K_NA, '0, 32'hA5A50000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
